// File: rtl/fifo_read_master_pkg.sv
// ============================================================================
// Module      : fifo_read_master_pkg
// Description : Shared FIFO/reader state encodings and FIFO address helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_read_master_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    typedef enum logic [2:0] {
        FIFO_IDLE     = 3'd0,
        FIFO_WRITE    = 3'd1,
        FIFO_READ     = 3'd2,
        FIFO_WR_ERROR = 3'd3,
        FIFO_RD_ERROR = 3'd4
    } fifo_state_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_RUN   = 2'b01,
        RD_FLUSH = 2'b10,
        RD_DONE  = 2'b11
    } rd_state_e;

    // Next FIFO address; wraps naturally at the power-of-two depth.
    function automatic logic [FIFO_AW-1:0] cal_addr(input logic [FIFO_AW-1:0] addr);
        return addr + FIFO_AW'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_read_master_skid_buf.sv
// ============================================================================
// Module      : rd_skid_buf
// Description : 2-entry circular output buffer with push/pop/flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_read_master.sv
// ============================================================================
// Module      : fifo_read_master
// Description : Pulls a programmed burst from the FIFO read port onto a
//               valid/ready stream, with retry on read errors and abort/flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_master
    import fifo_read_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            err_count
);

    rd_state_e        r_state;
    rd_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_issue_left;
    logic [CNT_W-1:0] r_recv_left;
    logic             r_inflight;
    logic [7:0]       r_err_count;

    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic             w_rd_en;
    logic             w_resp_ack;
    logic             w_resp_err;
    logic [1:0]       w_occ;
    logic [1:0]       w_occ_nxt;
    logic [2:0]       w_level;
    logic [CNT_W-1:0] w_recv_nxt;

    // Responses only count when a read is actually outstanding.
    assign w_resp_ack = r_inflight && fifo_rd_ack;
    assign w_resp_err = r_inflight && fifo_rd_err && !fifo_rd_ack;

    assign w_pop   = m_valid && m_ready;
    assign w_level = {1'b0, w_occ} + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_en = (r_state == RD_RUN) && !abort && (r_issue_left != '0)
                     && !fifo_empty && (w_level < 3'd2);

    assign w_push     = w_resp_ack && (r_state == RD_RUN) && !abort;
    assign w_flush    = (r_state == RD_FLUSH) && (!r_inflight || fifo_rd_ack || fifo_rd_err);
    assign w_occ_nxt  = w_occ + 2'(w_push) - 2'(w_pop);
    assign w_recv_nxt = r_recv_left - CNT_W'(w_push);

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (fifo_dout),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_occ   (w_occ)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: begin
                if (start) begin
                    w_state_nxt = (burst_len == '0) ? RD_DONE : RD_RUN;
                end
            end
            RD_RUN: begin
                if (abort) begin
                    w_state_nxt = RD_FLUSH;
                end else if ((w_recv_nxt == '0) && (w_occ_nxt == 2'd0)) begin
                    w_state_nxt = RD_DONE;
                end
            end
            RD_FLUSH: begin
                if (w_flush) begin
                    w_state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                w_state_nxt = abort ? RD_FLUSH : RD_IDLE;
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RD_IDLE;
            r_issue_left <= '0;
            r_recv_left  <= '0;
            r_inflight   <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if ((r_state == RD_IDLE) && start) begin
                r_issue_left <= burst_len;
                r_recv_left  <= burst_len;
            end else if (r_state == RD_RUN) begin
                // A refused read is handed back to the issue counter for retry.
                r_issue_left <= r_issue_left - CNT_W'(w_rd_en) + CNT_W'(w_resp_err);
                r_recv_left  <= w_recv_nxt;
            end
            if (w_resp_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign rd_en     = w_rd_en;
    assign busy      = (r_state != RD_IDLE);
    assign done      = (r_state == RD_DONE);
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_master.sv
// ============================================================================
// Module      : tb_fifo_read_master
// Description : Directed bench with a FIFO read-port model and a data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_read_master;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk         = 1'b0;
    logic          reset_n     = 1'b0;
    logic          start       = 1'b0;
    logic [CW-1:0] burst_len   = '0;
    logic          abort       = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_ack = 1'b0;
    logic          fifo_rd_err = 1'b0;
    logic [DW-1:0] fifo_dout   = '0;
    logic          m_ready     = 1'b0;
    logic          rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
    logic [7:0]    err_count;

    fifo_read_master #(
        .DATA_WIDTH (DW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .burst_len   (burst_len),
        .abort       (abort),
        .fifo_empty  (fifo_empty),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_rd_err (fifo_rd_err),
        .fifo_dout   (fifo_dout),
        .rd_en       (rd_en),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // FIFO read-port model: one-cycle response, optional forced error on one read.
    logic [DW-1:0] f_mem [16];
    logic [3:0]    f_wp     = '0;
    logic [3:0]    f_rp     = '0;
    logic [4:0]    f_cnt    = '0;
    logic          wr_en    = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          fifo_clr = 1'b0;
    int            rd_num   = 0;
    int            err_at   = -1;
    logic          m_rd_ok;

    assign fifo_empty = (f_cnt == 5'd0);
    always_comb m_rd_ok = rd_en && (f_cnt != 5'd0) && (rd_num != err_at);

    always @(posedge clk) begin
        fifo_rd_ack <= 1'b0;
        fifo_rd_err <= 1'b0;
        if (fifo_clr) begin
            f_wp  <= '0;
            f_rp  <= '0;
            f_cnt <= '0;
        end else begin
            if (wr_en) begin
                f_mem[f_wp] <= wr_data;
                f_wp        <= f_wp + 4'd1;
            end
            if (rd_en) begin
                rd_num <= rd_num + 1;
                if (m_rd_ok) begin
                    fifo_rd_ack <= 1'b1;
                    fifo_dout   <= f_mem[f_rp];
                    f_rp        <= f_rp + 4'd1;
                end else begin
                    fifo_rd_err <= 1'b1;
                end
            end
            f_cnt <= f_cnt + 5'(wr_en) - 5'(m_rd_ok);
        end
    end

    logic [DW-1:0] exp_q [$];
    int            total   = 0;
    int            bad     = 0;
    int            acks_n  = 0;
    int            pops_n  = 0;
    logic          chk_occ = 1'b0;
    logic          mon_stall = 1'b0;
    logic [DW-1:0] mon_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (fifo_rd_ack) acks_n <= acks_n + 1;
        if (m_valid && m_ready && reset_n) pops_n <= pops_n + 1;
    end

    // Output monitor: scoreboard pops, stall stability, buffered+in-flight bound.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", m_data, mon_data);
                end
                if (m_valid && m_ready) begin
                    chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("sb_data", m_data, exp_q.pop_front());
                end
                if (chk_occ) begin
                    chk("occ_bound", 32'((acks_n - pops_n + int'(fifo_rd_ack | fifo_rd_err)) <= 2), 32'd1);
                end
                mon_stall = m_valid && !m_ready;
                mon_data  = m_data;
            end
        end
    end

    task automatic fifo_write(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic fifo_reset_model();
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
    endtask

    task automatic kick(input int n);
        burst_len = CW'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, m_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int rd_ones, rd_late, done_at, dn, k;
        logic busy9, mv_done;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        fifo_reset_model();

        // Full-throughput burst of 5 with downstream always ready.
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) fifo_write(DW'(i * 32'h11));
        kick(5);
        rd_ones = 0; rd_late = 0; done_at = 0; busy9 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (rd_en && c <= 5) rd_ones++;
            if (rd_en && c > 5) rd_late++;
            if (done && done_at == 0) done_at = c;
            if (c == 9) busy9 = busy;
            @(negedge clk);
        end
        chk("t1_rd_en_burst", 32'(rd_ones), 32'd5);
        chk("t1_rd_en_after", 32'(rd_late), 32'd0);
        chk("t1_done_cycle", 32'(done_at), 32'd8);
        chk("t1_busy_fall", 32'(busy9), 32'd0);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Same burst with downstream ready pattern 1,0,0,1,0,0...
        chk_occ = 1'b1;
        for (int i = 1; i <= 5; i++) fifo_write(DW'(i * 32'h11));
        kick(5);
        k = 0;
        while (k < 80 && !done) begin
            m_ready = (k % 3 == 0);
            @(negedge clk);
            k++;
        end
        chk("t2_done", 32'(done), 32'd1);
        chk_occ = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty FIFO: no reads until words arrive.
        kick(3);
        rd_ones = 0;
        for (int c = 0; c < 10; c++) begin
            if (rd_en) rd_ones++;
            @(negedge clk);
        end
        chk("t3_no_rd_when_empty", 32'(rd_ones), 32'd0);
        chk("t3_busy_waiting", 32'(busy), 32'd1);
        fifo_write(32'hA1);
        fifo_write(32'hA2);
        fifo_write(32'hA3);
        wait_done("t3_done", 40);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Second read of a 4-word burst refused, then retried.
        err_at = rd_num + 1;
        for (int i = 1; i <= 4; i++) fifo_write(32'hB0 + DW'(i));
        kick(4);
        wait_done("t4_done", 40);
        chk("t4_err_count", 32'(err_count), 32'd1);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        err_at = -1;

        // Abort with a response in flight; concurrent start ignored.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) fifo_write(32'hC0 + DW'(i));
        kick(5);
        @(negedge clk);
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("t5_rd_en_before", 32'(rd_en), 32'd1);
        chk("t5_valid_before", 32'(m_valid), 32'd1);
        abort     = 1'b1;
        start     = 1'b1;
        burst_len = CW'(2);
        #1;
        chk("t5_rd_en_drop", 32'(rd_en), 32'd0);
        @(negedge clk);
        abort   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        dn = 0; rd_ones = 0; mv_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                dn++;
                mv_done = m_valid;
            end
            if (rd_en) rd_ones++;
            @(negedge clk);
        end
        chk("t5_done_once", 32'(dn), 32'd1);
        chk("t5_no_reads", 32'(rd_ones), 32'd0);
        chk("t5_flushed", 32'(mv_done), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        exp_q.delete();
        fifo_reset_model();

        // Zero-length burst.
        m_ready = 1'b1;
        kick(0);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_no_rd", 32'(rd_en), 32'd0);
        @(negedge clk);
        chk("t6_done_end", 32'(done), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-burst.
        for (int i = 1; i <= 5; i++) fifo_write(32'hD0 + DW'(i));
        kick(5);
        @(negedge clk);
        @(negedge clk);
        chk("t7_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t7_async");
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        fifo_reset_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fifo_read_master.md
Name: fifo_read_master

Overview:
- Read-side master for the 8-entry FIFO: drives the FIFO's read enable and consumes its read acknowledge/error responses.
- On a start command it pulls a programmed number of words from the FIFO and forwards them downstream on a valid/ready stream.
- A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so downstream stalls never lose or duplicate data.
- Sits between the FIFO's read port and any consumer (display, checker, serializer).

Parameters:
DATA_WIDTH, 32, FIFO data word width
CNT_W, 4, width of FIFO data count and burst length

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a burst; ignored unless idle
burst_len  input  CNT_W  words to read, 0..15, sampled with start
abort  input  1  stop issuing reads, drain in-flight, flush buffer
fifo_empty  input  1  FIFO empty flag
fifo_rd_ack  input  1  FIFO read accepted; fifo_dout valid this cycle
fifo_rd_err  input  1  FIFO read refused (was empty)
fifo_dout  input  DATA_WIDTH  FIFO read data
rd_en  output  1  read request to FIFO
m_valid  output  1  downstream data valid
m_data  output  DATA_WIDTH  downstream data
m_ready  input  1  downstream accepts when high with m_valid
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
err_count  output  8  saturating count of fifo_rd_err responses

Behaviour:
- Interface is fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: rd_en=0, m_valid=0, m_data=0, busy=0, done=0, err_count=0. All counters and pointers are 0; state is IDLE.
- FIFO contract: rd_en is sampled at edge T. At T+1 the FIFO asserts exactly one of fifo_rd_ack or fifo_rd_err, and fifo_dout is valid with the ack. At most one read is in flight.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on start, go to RUN with issue_left = recv_left = burst_len.
  - If burst_len = 0, go directly to DONE.
- RUN:
  - pop = m_valid & m_ready.
  - rd_en = (issue_left != 0) & !fifo_empty & ((occ + inflight - pop) < 2), where occ is buffer occupancy 0..2.
  - The rd_en term is combinational from m_ready. Full throughput of 1 word/cycle is required when the FIFO is non-empty and m_ready=1.
  - An issued read decrements issue_left and sets inflight.
  - fifo_rd_ack: push fifo_dout into the buffer and decrement recv_left.
  - fifo_rd_err: increment issue_left (the word is retried) and increment err_count, saturating at 255.
  - When recv_left = 0 and occ = 0 (after pop), go to DONE.
- abort (any non-IDLE state): rd_en is forced 0 immediately; go to FLUSH.
- FLUSH:
  - Wait for any in-flight response. An acked word is discarded.
  - Then clear the buffer (m_valid = 0) and go to DONE.
  - abort has priority over start and over normal completion in the same cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in RUN, FLUSH and DONE; 0 in IDLE. start while busy is ignored.
- Output buffer:
  - 2-entry circular buffer with 1-bit pointers that wrap.
  - m_data = head entry; m_valid = (occ != 0).
  - m_data and m_valid are held stable while m_valid & !m_ready.
  - Push and pop in the same cycle leave occ unchanged.
- Width rules: counters are CNT_W bits; issue_left never exceeds burst_len and never underflows. No read is issued when issue_left = 0.
- fifo_rd_ack or fifo_rd_err arriving while no read is in flight is ignored, and err_count is unchanged.

Decomposition:
- Shared package/include (with the FIFO's cal_addr logic): FIFO state encodings IDLE/WRITE/READ/WR_ERROR/RD_ERROR, and the reader states IDLE=2'b00, RUN=2'b01, FLUSH=2'b10, DONE=2'b11.
- One sub-module: rd_skid_buf, the 2-entry buffer with push/pop/occ.

Test Plan:
- FIFO preloaded with 0x11..0x55 (5 words), burst_len=5, m_ready=1: rd_en high 5 consecutive cycles; m_data = 0x11,0x22,0x33,0x44,0x55 on consecutive cycles; done pulses 1 cycle after the last pop; busy falls with it.
- Same preload with m_ready toggling 1,0,0,1...: no word lost or duplicated, m_data stable while stalled, and rd_en never leaves more than 2 words buffered or in flight.
- FIFO empty, burst_len=3, then 3 writes after 10 cycles: rd_en stays 0 while fifo_empty=1; all 3 words are delivered after the writes.
- Force fifo_rd_err on the second read of a 4-word burst: err_count=1, the read is retried, 4 words are delivered in order, and done is asserted.
- abort asserted with 1 read in flight and occ=2: rd_en drops the same cycle, m_valid=0 after the flush, and done pulses once. A start in the same cycle as abort is ignored.
- burst_len=0 → done the cycle after start, and rd_en never asserts. Assert reset_n=0 mid-burst → all outputs go to reset values immediately.
